// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M iterative multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_e;

  localparam logic [XLEN-1:0] DIV0_QUOT = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] OVF_QUOT  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] OVF_REM   = {XLEN{1'b0}};

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: LSB-first shift-add multiply or MSB-first restoring divide.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic               i_div,
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_opb,
  output logic [2*WIDTH-1:0] o_acc
);

  logic [WIDTH-1:0] w_hi;
  logic [WIDTH-1:0] w_lo;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_fits;

  assign w_hi = i_acc[2*WIDTH-1:WIDTH];
  assign w_lo = i_acc[WIDTH-1:0];

  // Multiply: hi accumulates the partial product, lo holds the remaining multiplier bits.
  assign w_sum = {1'b0, w_hi} + (w_lo[0] ? {1'b0, i_opb} : {(WIDTH+1){1'b0}});

  // Divide: hi is the partial remainder, lo shifts dividend bits out and quotient bits in.
  assign w_shift = {w_hi, w_lo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, i_opb};
  assign w_fits  = ~w_diff[WIDTH];

  always_comb begin
    o_acc = {w_sum, w_lo[WIDTH-1:1]};
    if (i_div) begin
      o_acc = {(w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0]), w_lo[WIDTH-2:0], w_fits};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multi-cycle multiply/divide unit for the execute stage; stalls F/D/E until done.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             E_muldiv_start,
  input  logic [2:0]       E_muldiv_op,
  input  logic [WIDTH-1:0] E_rs1,
  input  logic [WIDTH-1:0] E_rs2,
  input  logic             E_flush,
  output logic             E_muldiv_stall,
  output logic             E_muldiv_done,
  output logic [WIDTH-1:0] E_muldiv_result
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]    L_LAST     = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] L_ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] L_INT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

  muldiv_state_e      r_state;
  logic [2:0]         r_op;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opb;
  logic [WIDTH-1:0]   r_result;
  logic               r_neg;
  logic               r_neg_rem;

  logic               w_a_signed;
  logic               w_b_signed;
  logic               w_sa;
  logic               w_sb;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic               w_is_div;
  logic               w_div0;
  logic               w_ovf;
  logic [WIDTH-1:0]   w_special;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_final;

  assign w_a_signed = E_muldiv_op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  assign w_b_signed = E_muldiv_op inside {OP_MULH, OP_DIV, OP_REM};
  assign w_sa       = w_a_signed & E_rs1[WIDTH-1];
  assign w_sb       = w_b_signed & E_rs2[WIDTH-1];
  assign w_mag_a    = w_sa ? -E_rs1 : E_rs1;
  assign w_mag_b    = w_sb ? -E_rs2 : E_rs2;

  assign w_is_div  = E_muldiv_op[2];
  assign w_div0    = w_is_div & (E_rs2 == '0);
  assign w_ovf     = (E_muldiv_op inside {OP_DIV, OP_REM}) &
                     (E_rs1 == L_INT_MIN) & (E_rs2 == L_ALL_ONES);
  // op[1] separates REM/REMU from DIV/DIVU within the divide group
  assign w_special = w_div0 ? (E_muldiv_op[1] ? E_rs1 : L_ALL_ONES)
                            : (E_muldiv_op[1] ? '0 : L_INT_MIN);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_div (r_op[2]),
    .i_acc (r_acc),
    .i_opb (r_opb),
    .o_acc (w_acc_nxt)
  );

  assign w_prod = r_neg ? -w_acc_nxt : w_acc_nxt;
  assign w_quot = r_neg ? -w_acc_nxt[WIDTH-1:0] : w_acc_nxt[WIDTH-1:0];
  assign w_rem  = r_neg_rem ? -w_acc_nxt[2*WIDTH-1:WIDTH] : w_acc_nxt[2*WIDTH-1:WIDTH];

  always_comb begin
    w_final = w_prod[2*WIDTH-1:WIDTH];
    case (r_op)
      OP_MUL:           w_final = w_prod[WIDTH-1:0];
      OP_DIV, OP_DIVU:  w_final = w_quot;
      OP_REM, OP_REMU:  w_final = w_rem;
      default:          w_final = w_prod[2*WIDTH-1:WIDTH];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_op      <= '0;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_opb     <= '0;
      r_result  <= '0;
      r_neg     <= 1'b0;
      r_neg_rem <= 1'b0;
    end else if (E_flush) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (E_muldiv_start) begin
            r_op      <= E_muldiv_op;
            r_neg     <= w_sa ^ w_sb;
            r_neg_rem <= w_sa;
            r_cnt     <= '0;
            if (w_div0 || w_ovf) begin
              r_result <= w_special;
              r_state  <= ST_DONE;
            end else begin
              // Divide shifts the dividend through lo; multiply shifts the multiplier.
              r_acc   <= {{WIDTH{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
              r_opb   <= w_is_div ? w_mag_b : w_mag_a;
              r_state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          r_acc <= w_acc_nxt;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == L_LAST) begin
            r_result <= w_final;
            r_state  <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign E_muldiv_stall  = rst_n & (((r_state == ST_IDLE) & E_muldiv_start & ~E_flush) |
                                    (r_state == ST_CALC));
  assign E_muldiv_done   = (r_state == ST_DONE);
  assign E_muldiv_result = r_result;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multi-cycle unit for the RV32M instructions MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU, sitting beside the ALU in the execute stage.
- Sequences a shift-add multiplier and a restoring divider through an FSM.
- Stalls the pipeline until the result is ready.
- The hazard/stall logic ORs E_muldiv_stall into the F/D/E stall enables; the writeback mux selects E_muldiv_result when E_muldiv_done.

Parameters:
WIDTH  32  operand/result width (XLEN); iteration count = WIDTH

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset
E_muldiv_start  input  1  M-extension instruction present in E; held high while stalled
E_muldiv_op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
E_rs1  input  WIDTH  forwarded operand a (multiplicand/dividend)
E_rs2  input  WIDTH  forwarded operand b (multiplier/divisor)
E_flush  input  1  kill in-flight op (branch/jump flush of E)
E_muldiv_stall  output  1  hold F/D/E stages
E_muldiv_done  output  1  one-cycle pulse; E_muldiv_result valid
E_muldiv_result  output  WIDTH  registered result

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - rst_n low at a rising edge forces state IDLE, counter 0, all internal registers 0, E_muldiv_done=0, E_muldiv_result=0.
  - E_muldiv_stall is 0 while in reset.
  - Reset mid-operation abandons the op; no done pulse.
- States: IDLE, CALC, DONE.
- IDLE, start=1, flush=0:
  - Latch op and the operand magnitudes. Signed inputs: DIV/REM/MULH take both, MULHSU takes rs1 only.
  - Latch result sign: product sign = sa^sb; quotient sign = sa^sb; remainder sign = sa.
  - Special case, divide by zero (rs2==0): result = all-ones for DIV/DIVU, rs1 for REM/REMU. Next state DONE.
  - Special case, signed overflow (DIV/REM, rs1=0x80000000, rs2=0xFFFFFFFF): DIV -> 0x80000000, REM -> 0. Next state DONE.
  - Otherwise: counter=0, next state CALC.
- CALC, one iteration per cycle, WIDTH cycles:
  - Multiply: 2*WIDTH-bit product accumulator, shift-add on the multiplier LSB.
  - Divide: restoring step on a WIDTH+1-bit partial remainder, one quotient bit per cycle, MSB first.
  - On counter==WIDTH-1: apply the two's-complement sign fix and select the result word. MUL takes the low word; MULH/MULHSU/MULHU take the high word; DIV/DIVU the quotient; REM/REMU the remainder.
  - Register the result into E_muldiv_result, then go to DONE.
- DONE:
  - E_muldiv_done=1 and E_muldiv_stall=0 for exactly this cycle; the pipeline advances.
  - Next state IDLE unconditionally; start is ignored in DONE, so the same instruction is never relaunched.
- E_muldiv_stall = (IDLE & start & ~flush) | CALC. Combinational from state and start.
- Latency, normal op: start seen at cycle 0; stall high cycles 0..WIDTH (33 cycles); done at cycle WIDTH+1.
- Latency, special case: stall high at cycle 0 only; done at cycle 1.
- Back-to-back: a new start in the IDLE cycle after DONE launches a new op; at most one op in flight.
- Flush:
  - E_flush=1 in any state gives next state IDLE; in-flight work is discarded and no done pulse is generated.
  - Flush has priority over start in IDLE.
  - Stall drops in the flush cycle when in IDLE; from CALC, stall drops the cycle after.
- E_muldiv_result holds its last value until the next completion. Operands are sampled only at launch, so later input changes are ignored.
- Arithmetic width: all internal arithmetic is unsigned on magnitudes; negation is a two's complement at the WIDTH or 2*WIDTH width.

Decomposition:
- Shared package muldiv_pkg:
  - enum muldiv_op_e for the funct3 codes.
  - enum muldiv_state_e {IDLE, CALC, DONE}.
  - Constants for the div-by-zero and overflow results.
- One natural sub-module: muldiv_step. Combinational single iteration (shift-add or restoring subtract) instantiated inside the FSM.

Test Plan:
- MUL 7 * 0xFFFFFFFD (-3) -> result 0xFFFFFFEB; stall high exactly 33 cycles; done pulse at cycle 33.
- MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2.
- DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0. Each: stall 1 cycle, done at cycle 1.
- Flush at cycle 10 of CALC -> IDLE next cycle, stall 0, no done pulse; then DIVU 100/7 started -> 14 after normal latency.
- rst_n low for one cycle mid-CALC -> result 0, done 0, stall 0; back-to-back MUL 3*4 then MUL 5*6 -> results 12 then 30, each with full latency.
